shadow_restore_sequencer: RTL and testbench

//  Sequences the restore of the interrupt shadow register file from the stack frame that
//  the shadow save path wrote, issuing one XLEN-wide load per register on the dcache load port.

---
 rtl/shadow_restore_sequencer_if.sv | 41 ++++
 rtl/shadow_restore_sequencer.sv | 105 ++++++++++
 tb/tb_shadow_restore_sequencer.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/shadow_restore_sequencer_if.sv
// ---------------------------------------------------------------------------
// shadow_restore_sequencer_if: CSR trigger, dcache load, shadow write, mret gate
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface shadow_restore_sequencer_if #(
  parameter int XLEN  = 64,
  parameter int PLEN  = 56,
  parameter int IDX_W = 4
);
  logic             restore_req_i;
  logic             restore_ack_o;
  logic [XLEN-1:0]  sp_i;
  logic             ld_req_o;
  logic             ld_gnt_i;
  logic [PLEN-1:0]  ld_addr_o;
  logic             ld_rvalid_i;
  logic [XLEN-1:0]  ld_rdata_i;
  logic             shreg_we_o;
  logic [IDX_W-1:0] shreg_waddr_o;
  logic [XLEN-1:0]  shreg_wdata_o;
  logic [IDX_W:0]   restore_level_o;
  logic             busy_o;
  logic             mret_valid_i;
  logic             mret_ready_o;

  modport master (
    input  restore_req_i, sp_i, ld_gnt_i, ld_rvalid_i, ld_rdata_i, mret_valid_i,
    output restore_ack_o, ld_req_o, ld_addr_o, shreg_we_o, shreg_waddr_o,
           shreg_wdata_o, restore_level_o, busy_o, mret_ready_o
  );

  modport slave (
    output restore_req_i, sp_i, ld_gnt_i, ld_rvalid_i, ld_rdata_i, mret_valid_i,
    input  restore_ack_o, ld_req_o, ld_addr_o, shreg_we_o, shreg_waddr_o,
           shreg_wdata_o, restore_level_o, busy_o, mret_ready_o
  );
endinterface

`default_nettype wire

// File: rtl/shadow_restore_sequencer.sv
// ---------------------------------------------------------------------------
// shadow_restore_sequencer: reloads the shadow regfile from its stack frame
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module shadow_restore_sequencer #(
  parameter int XLEN            = 64,
  parameter int PLEN            = 56,
  parameter int NUM_REGS        = 16,
  parameter int IDX_W           = $clog2(NUM_REGS),
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  shadow_restore_sequencer_if.master  bus
);

  localparam int               OUT_W    = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [XLEN-1:0]  STRIDE   = XLEN'(XLEN / 8);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REGS - 1);
  localparam logic [IDX_W:0]   LVL_ONE  = (IDX_W + 1)'(1);
  localparam logic [IDX_W:0]   LVL_FULL = (IDX_W + 1)'(NUM_REGS);
  localparam logic [OUT_W-1:0] OUT_ONE  = OUT_W'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

  state_e           state_q, state_d;
  logic [XLEN-1:0]  addr_q;
  logic [IDX_W-1:0] iss_idx_q;
  logic [IDX_W-1:0] wr_idx_q;
  logic [IDX_W:0]   level_q;
  logic [OUT_W-1:0] outstanding_q;

  logic busy, ack, req, grant, rsp;

  always_comb begin
    busy    = (state_q == ISSUE) || (state_q == DRAIN);
    ack     = (state_q == IDLE) && bus.restore_req_i;
    req     = (state_q == ISSUE) && (int'(outstanding_q) < MAX_OUTSTANDING);
    grant   = req && bus.ld_gnt_i;
    // Stray or post-reset responses are dropped: only tracked loads write back.
    rsp     = busy && bus.ld_rvalid_i && (outstanding_q != '0);
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (ack) state_d = ISSUE;
      ISSUE:   if (grant && (iss_idx_q == '0)) state_d = DRAIN;
      DRAIN:   if (rsp && (level_q == LVL_ONE)) state_d = DONE;
      DONE:    if (bus.mret_valid_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.restore_ack_o   = ack;
  assign bus.ld_req_o        = req;
  assign bus.ld_addr_o       = addr_q[PLEN-1:0];
  assign bus.shreg_we_o      = rsp;
  assign bus.shreg_waddr_o   = wr_idx_q;
  assign bus.shreg_wdata_o   = bus.ld_rdata_i;
  assign bus.restore_level_o = level_q;
  assign bus.busy_o          = busy;
  assign bus.mret_ready_o    = !busy;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      iss_idx_q     <= '0;
      wr_idx_q      <= '0;
      level_q       <= '0;
      outstanding_q <= '0;
    end else begin
      state_q <= state_d;
      if (ack) begin
        addr_q        <= bus.sp_i - STRIDE;
        iss_idx_q     <= IDX_LAST;
        wr_idx_q      <= IDX_LAST;
        level_q       <= LVL_FULL;
        outstanding_q <= '0;
      end else begin
        if (grant) begin
          addr_q    <= addr_q - STRIDE;
          iss_idx_q <= iss_idx_q - IDX_ONE;
        end
        if (rsp) begin
          wr_idx_q <= wr_idx_q - IDX_ONE;
          level_q  <= level_q - LVL_ONE;
        end
        if (grant && !rsp)      outstanding_q <= outstanding_q + OUT_ONE;
        else if (rsp && !grant) outstanding_q <= outstanding_q - OUT_ONE;
      end
    end
  end

  a_rsp_tracked: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (busy && bus.ld_rvalid_i) |-> (outstanding_q != '0));
  a_out_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    int'(outstanding_q) <= MAX_OUTSTANDING);
  a_level_idx: assert property (@(posedge clk_i) disable iff (!rst_ni)
    busy |-> (level_q == ({1'b0, wr_idx_q} + LVL_ONE)));

endmodule

`default_nettype wire

// File: tb/tb_shadow_restore_sequencer.sv
// ---------------------------------------------------------------------------
// tb_shadow_restore_sequencer: random handshakes against a frame-level model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_shadow_restore_sequencer;

  localparam int XLEN     = 64;
  localparam int PLEN     = 56;
  localparam int NUM_REGS = 16;
  localparam int IDX_W    = 4;
  localparam int MAXO     = 2;
  localparam int STRIDE   = XLEN / 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  shadow_restore_sequencer_if #(.XLEN(XLEN), .PLEN(PLEN), .IDX_W(IDX_W)) bus ();

  shadow_restore_sequencer #(
    .XLEN(XLEN), .PLEN(PLEN), .NUM_REGS(NUM_REGS), .IDX_W(IDX_W), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 restoring, 2 complete awaiting mret
  int          phase = 0;
  logic [63:0] frame_sp;
  int          n_iss, n_wr, cyc = 0;
  int          ack_cyc, last_wr_cyc;
  logic [63:0] pend_addr[$];
  int          pend_due[$];
  logic [63:0] key;
  int          gnt_pct, lat_lo, lat_hi, hold_at, hold_left;

  function automatic logic [63:0] trunc(input logic [63:0] a);
    return a & ((64'd1 << PLEN) - 64'd1);
  endfunction

  function automatic logic [63:0] reg_addr(input int k);
    return trunc(frame_sp - 64'((NUM_REGS - k) * STRIDE));
  endfunction

  function automatic logic [63:0] mem_word(input logic [63:0] a);
    return (a * 64'h9E37_79B9_7F4A_7C15) ^ key;
  endfunction

  task automatic cycle_step(input bit req_in, input logic [63:0] sp_in, input bit mret_in);
    bit g, rv, exp_req;
    @(negedge clk);
    g = ($urandom_range(99) < gnt_pct);
    if (phase == 1 && n_iss == hold_at && hold_left > 0) begin
      g = 1'b0;
      hold_left--;
    end
    rv = (phase == 1) && (pend_due.size() > 0) && (pend_due[0] <= cyc);
    bus.restore_req_i = req_in;
    bus.sp_i          = sp_in;
    bus.ld_gnt_i      = g;
    bus.ld_rvalid_i   = rv;
    bus.ld_rdata_i    = rv ? mem_word(pend_addr[0]) : {$urandom, $urandom};
    bus.mret_valid_i  = mret_in;
    #1;
    exp_req = (phase == 1) && (n_iss < NUM_REGS) && ((n_iss - n_wr) < MAXO);
    check_eq("busy", 64'(bus.busy_o), 64'(phase == 1));
    check_eq("mret_ready", 64'(bus.mret_ready_o), 64'(phase != 1));
    check_eq("restore_ack", 64'(bus.restore_ack_o), 64'(phase == 0 && req_in));
    check_eq("ld_req", 64'(bus.ld_req_o), 64'(exp_req));
    if (exp_req) check_eq("ld_addr", 64'(bus.ld_addr_o), reg_addr(NUM_REGS - 1 - n_iss));
    check_eq("level", 64'(bus.restore_level_o), (phase == 1) ? 64'(NUM_REGS - n_wr) : 64'd0);
    check_eq("shreg_we", 64'(bus.shreg_we_o), 64'(rv));
    if (rv) begin
      check_eq("shreg_waddr", 64'(bus.shreg_waddr_o), 64'(NUM_REGS - 1 - n_wr));
      check_eq("shreg_wdata", bus.shreg_wdata_o, mem_word(reg_addr(NUM_REGS - 1 - n_wr)));
    end
    // Clock edge as seen by the model
    if (bus.ld_req_o && g) begin
      pend_addr.push_back(64'(bus.ld_addr_o));
      pend_due.push_back(cyc + int'($urandom_range(lat_hi, lat_lo)));
      n_iss++;
    end
    case (phase)
      0: if (req_in) begin
           phase = 1; frame_sp = sp_in; n_iss = 0; n_wr = 0; ack_cyc = cyc;
         end
      1: if (rv) begin
           void'(pend_addr.pop_front());
           void'(pend_due.pop_front());
           n_wr++;
           if (n_wr == NUM_REGS) begin phase = 2; last_wr_cyc = cyc; end
         end
      default: if (mret_in) phase = 0;
    endcase
    cyc++;
  endtask

  task automatic run_restore(input logic [63:0] sp, input int pct, input int lo, input int hi,
                             input int hold, input bit rand_mret, input int stop_after_wr);
    int budget;
    gnt_pct = pct; lat_lo = lo; lat_hi = hi; hold_at = hold; hold_left = 5;
    cycle_step(1'b1, sp, 1'b0);
    budget = 600;
    while (phase != 0 && budget > 0 && !(stop_after_wr > 0 && n_wr >= stop_after_wr)) begin
      cycle_step($urandom_range(3) == 0, {$urandom, $urandom},
                 rand_mret ? 1'($urandom_range(1)) : (phase == 2));
      budget--;
    end
    if (stop_after_wr == 0) check_eq("restore_timeout", 64'(phase), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ack"},    64'(bus.restore_ack_o), 64'd0);
    check_eq({tag, "_ld_req"}, 64'(bus.ld_req_o), 64'd0);
    check_eq({tag, "_addr"},   64'(bus.ld_addr_o), 64'd0);
    check_eq({tag, "_we"},     64'(bus.shreg_we_o), 64'd0);
    check_eq({tag, "_level"},  64'(bus.restore_level_o), 64'd0);
    check_eq({tag, "_busy"},   64'(bus.busy_o), 64'd0);
    check_eq({tag, "_mret"},   64'(bus.mret_ready_o), 64'd1);
  endtask

  initial begin
    bus.restore_req_i = 1'b0; bus.sp_i = '0; bus.ld_gnt_i = 1'b0; bus.ld_rvalid_i = 1'b0;
    bus.ld_rdata_i = '0; bus.mret_valid_i = 1'b0;
    key = {$urandom, $urandom};
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    @(negedge clk) rst_n = 1'b1;

    // Back-to-back grants, single-cycle responses
    run_restore(64'h8000_1000, 100, 1, 1, -1, 1'b0, 0);
    check_eq("t1_latency", 64'(last_wr_cyc - ack_cyc), 64'd17);
    // Third request stalled for five cycles
    run_restore(64'h8000_2000, 100, 1, 2, 2, 1'b0, 0);
    // Long response latency saturates the outstanding window
    run_restore(64'h8000_3000, 100, 10, 10, -1, 1'b0, 0);
    // Random mret attempts while the restore is in flight
    run_restore({$urandom, $urandom}, 100, 1, 3, -1, 1'b1, 0);
    for (int i = 0; i < 6; i++)
      run_restore({$urandom, $urandom}, int'($urandom_range(100, 30)), 1,
                  int'($urandom_range(8, 1)), -1, 1'b1, 0);

    // Abort mid-restore with loads still in flight
    run_restore(64'h8000_4000, 100, 2, 3, -1, 1'b0, 7);
    check_eq("pre_abort_writes", 64'(n_wr), 64'd7);
    #2;
    bus.restore_req_i = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    phase = 0; pend_addr.delete(); pend_due.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    bus.ld_rvalid_i = 1'b1;
    bus.ld_gnt_i = 1'b1;
    #1;
    check_eq("late_rvalid_we", 64'(bus.shreg_we_o), 64'd0);
    check_eq("late_rvalid_level", 64'(bus.restore_level_o), 64'd0);
    bus.ld_rvalid_i = 1'b0;
    run_restore(64'h8000_5000, 80, 1, 4, -1, 1'b1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
